// File: rtl/as512512512_uart_ctrl.sv
// rtl/as512512512_uart_ctrl.sv - register-mapped TX/RX sequencer with byte FIFOs for the as512512512 UART core
// Circular byte FIFO; a pop frees a slot for a push in the same cycle.

module as512512512_uart_ctrl_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       empty,
    output logic       full
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  pop_ok;
    logic                  push_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module as512512512_uart_ctrl #(
    parameter int          DEPTH_LOG2 = 2,
    parameter logic [15:0] DIV_RESET  = 16'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    output logic        irq,
    output logic [15:0] divisor,
    output logic [7:0]  uart_din,
    output logic        uart_start,
    output logic        uart_clr_hb,
    input  logic        uart_busy,
    input  logic        uart_has_byte,
    input  logic [7:0]  uart_dout
);
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_DIV_LO = 2'd2;
    localparam logic [1:0] A_DIV_HI = 2'd3;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_state_t;
    typedef enum logic {RX_IDLE, RX_CLR} rx_state_t;

    tx_state_t  tx_state;
    rx_state_t  rx_state;
    logic       overrun;
    logic       rx_ie;
    logic       tx_ie;

    logic       tx_push;
    logic       tx_pop;
    logic [7:0] tx_head;
    logic       tx_empty;
    logic       tx_full;
    logic       rx_push;
    logic       rx_pop;
    logic [7:0] rx_head;
    logic       rx_empty;
    logic       rx_full;
    logic       tx_busy;
    logic [7:0] status;

    assign tx_push = we & (addr == A_DATA);
    assign tx_pop  = (tx_state == IDLE) & ~tx_empty;
    assign rx_push = (rx_state == RX_IDLE) & uart_has_byte;
    assign rx_pop  = re & (addr == A_DATA);
    assign tx_busy = (tx_state != IDLE) | ~tx_empty;
    assign status  = {tx_ie, rx_ie, 1'b0, overrun, tx_busy, tx_full, rx_full, ~rx_empty};
    assign irq     = (~rx_empty & rx_ie) | (tx_empty & tx_ie);

    as512512512_uart_ctrl_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (wdata),
        .pop       (tx_pop),
        .head      (tx_head),
        .empty     (tx_empty),
        .full      (tx_full)
    );

    as512512512_uart_ctrl_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (uart_dout),
        .pop       (rx_pop),
        .head      (rx_head),
        .empty     (rx_empty),
        .full      (rx_full)
    );

    // Register file and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata   <= '0;
            divisor <= DIV_RESET;
            overrun <= 1'b0;
            rx_ie   <= 1'b0;
            tx_ie   <= 1'b0;
        end else begin
            if (we) begin
                case (addr)
                    A_STATUS: begin
                        rx_ie <= wdata[6];
                        tx_ie <= wdata[7];
                    end
                    A_DIV_LO: divisor[7:0]  <= wdata;
                    A_DIV_HI: divisor[15:8] <= wdata;
                    default:  ;
                endcase
            end
            // A byte lost in the same cycle as a clear still leaves overrun set
            if (rx_push & rx_full & ~rx_pop) begin
                overrun <= 1'b1;
            end else if (we & (addr == A_STATUS) & wdata[0]) begin
                overrun <= 1'b0;
            end
            if (re) begin
                case (addr)
                    A_DATA:   rdata <= rx_empty ? 8'h00 : rx_head;
                    A_STATUS: rdata <= status;
                    A_DIV_LO: rdata <= divisor[7:0];
                    default:  rdata <= divisor[15:8];
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state   <= IDLE;
            uart_din   <= '0;
            uart_start <= 1'b0;
        end else begin
            uart_start <= 1'b0;
            case (tx_state)
                IDLE: begin
                    if (tx_pop) begin
                        uart_din   <= tx_head;
                        uart_start <= 1'b1;
                        tx_state   <= LAUNCH;
                    end
                end
                LAUNCH:    tx_state <= WAIT_BUSY;
                WAIT_BUSY: if (uart_busy) tx_state <= WAIT_DONE;
                WAIT_DONE: if (!uart_busy) tx_state <= IDLE;
                default:   tx_state <= IDLE;
            endcase
        end
    end

    // has_byte stays high until the core sees clr_hb, so wait it out before re-arming
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            uart_clr_hb <= 1'b0;
        end else begin
            uart_clr_hb <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (uart_has_byte) begin
                        uart_clr_hb <= 1'b1;
                        rx_state    <= RX_CLR;
                    end
                end
                RX_CLR:  if (!uart_has_byte) rx_state <= RX_IDLE;
                default: rx_state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_as512512512_uart_ctrl.sv
// tb/tb_as512512512_uart_ctrl.sv - directed self-checking bench for as512512512_uart_ctrl with a behavioural core model

module tb_as512512512_uart_ctrl;
    localparam int BUSY_LEN = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        we;
    logic        re;
    logic [7:0]  rdata;
    logic        irq;
    logic [15:0] divisor;
    logic [7:0]  uart_din;
    logic        uart_start;
    logic        uart_clr_hb;
    logic        uart_busy;
    logic        uart_has_byte;
    logic [7:0]  uart_dout;

    int ncmp = 0;
    int nerr = 0;
    int cyc = 0;
    int nstart = 0;
    int nclr = 0;
    int dbl = 0;
    int gap_bad = 0;
    int last_fall = 0;
    int ph = 0;
    logic prev_start = 1'b0;
    logic [7:0] txlog[$];
    logic [7:0] d;
    int snap;

    as512512512_uart_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .irq           (irq),
        .divisor       (divisor),
        .uart_din      (uart_din),
        .uart_start    (uart_start),
        .uart_clr_hb   (uart_clr_hb),
        .uart_busy     (uart_busy),
        .uart_has_byte (uart_has_byte),
        .uart_dout     (uart_dout)
    );

    always #5 clk = ~clk;

    // Core model: busy rises the cycle after start is seen, stays high BUSY_LEN cycles
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (uart_clr_hb) nclr++;
            if (uart_start) begin
                txlog.push_back(uart_din);
                nstart++;
                if (prev_start) dbl++;
                if (nstart > 1 && (cyc - last_fall) < 2) gap_bad++;
                ph = BUSY_LEN + 1;
            end else if (ph > 0) begin
                ph--;
                uart_busy = (ph != 0);
                if (ph == 0) last_fall = cyc;
            end
            prev_start = uart_start;
        end
    end

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] v);
        addr = a; wdata = v; we = 1'b1;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [7:0] v);
        addr = a; re = 1'b1;
        @(negedge clk);
        re = 1'b0;
        v = rdata;
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 3000 && txlog.size() < n; i++) @(negedge clk);
        chki("tx_count", txlog.size(), n);
        repeat (BUSY_LEN + 6) @(negedge clk);
    endtask

    task automatic inject(input logic [7:0] b);
        uart_has_byte = 1'b1;
        uart_dout = b;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (uart_clr_hb) break;
        end
        uart_has_byte = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        uart_has_byte = 1'b0; uart_dout = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk8("rst_rdata", rdata, 8'h00);
        chki("rst_irq", int'(irq), 0);
        chki("rst_divisor", int'(divisor), 103);
        chk8("rst_din", uart_din, 8'h00);
        chki("rst_clr_hb", int'(uart_clr_hb), 0);
        rd(2'd1, d); chk8("rst_status", d, 8'h00);
        rd(2'd2, d); chk8("rst_div_lo", d, 8'h67);
        rd(2'd3, d); chk8("rst_div_hi", d, 8'h00);
        chki("rst_no_start", nstart, 0);

        wr(2'd2, 8'h04);
        wr(2'd3, 8'h00);
        chki("div_set", int'(divisor), 4);
        wr(2'd0, 8'h55);
        wr(2'd0, 8'hA3);
        wait_tx(2);
        chk8("tx0", txlog[0], 8'h55);
        chk8("tx1", txlog[1], 8'hA3);

        // 1 in flight + 4 queued; sixth byte dropped
        wr(2'd0, 8'hC0); wr(2'd0, 8'hC1); wr(2'd0, 8'hC2);
        wr(2'd0, 8'hC3); wr(2'd0, 8'hC4); wr(2'd0, 8'hC5);
        rd(2'd1, d); chk8("tx_full_status", d, 8'h0C);
        wait_tx(7);
        for (int i = 0; i < 5; i++) chk8("tx_order", txlog[2 + i], 8'hC0 + 8'(i));
        rd(2'd1, d); chk8("tx_idle_status", d, 8'h00);

        wr(2'd0, 8'h3C);
        wait_tx(8);
        chk8("loop_tx", txlog[7], 8'h3C);
        inject(txlog[7]);
        chki("loop_clr_hb", nclr, 1);
        rd(2'd1, d); chk8("loop_status", d, 8'h01);
        rd(2'd0, d); chk8("loop_data", d, 8'h3C);
        rd(2'd1, d); chk8("loop_empty", d, 8'h00);
        rd(2'd0, d); chk8("empty_read", d, 8'h00);

        inject(8'h11); inject(8'h22); inject(8'h33); inject(8'h44); inject(8'h55);
        chki("ovr_clr_hb", nclr, 6);
        rd(2'd1, d); chk8("ovr_status", d, 8'h13);
        rd(2'd0, d); chk8("ovr_d0", d, 8'h11);
        rd(2'd0, d); chk8("ovr_d1", d, 8'h22);
        rd(2'd0, d); chk8("ovr_d2", d, 8'h33);
        rd(2'd0, d); chk8("ovr_d3", d, 8'h44);
        rd(2'd1, d); chk8("ovr_sticky", d, 8'h10);
        wr(2'd1, 8'h01);
        rd(2'd1, d); chk8("ovr_cleared", d, 8'h00);

        wr(2'd1, 8'h40);
        chki("irq_rx_idle", int'(irq), 0);
        inject(8'hAB);
        chki("irq_rx_set", int'(irq), 1);
        rd(2'd1, d); chk8("irq_status", d, 8'h41);
        chki("irq_rx_hold", int'(irq), 1);
        rd(2'd0, d); chk8("irq_data", d, 8'hAB);
        chki("irq_rx_clear", int'(irq), 0);
        wr(2'd1, 8'h80);
        chki("irq_tx_empty", int'(irq), 1);
        wr(2'd1, 8'h40);

        inject(8'h5A);
        wr(2'd0, 8'h77);
        for (int i = 0; i < 50 && !uart_busy; i++) @(negedge clk);
        chki("busy_seen", int'(uart_busy), 1);
        @(negedge clk);
        wr(2'd0, 8'h88);
        chki("pre_rst_irq", int'(irq), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chki("post_rst_irq", int'(irq), 0);
        snap = nstart;
        rd(2'd1, d); chk8("post_rst_status", d, 8'h00);
        rd(2'd0, d); chk8("post_rst_rx_empty", d, 8'h00);
        chki("post_rst_divisor", int'(divisor), 103);
        repeat (40) @(negedge clk);
        chki("post_rst_no_start", nstart, snap);

        chki("start_single_cycle", dbl, 0);
        chki("start_gap", gap_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
